// File: rtl/bcd_display_driver.sv
// bcd_display_driver
//   Time-multiplexed driver for a 4-digit common-anode 7-segment display.
//   Takes packed BCD from the binary-to-BCD stage, latches it into a pending
//   slot, and swaps it into the displayed word only at frame boundaries, so a
//   frame never shows a mix of old and new digits. Each digit is scanned for
//   DIGIT_PERIOD cycles. Leading zeros are blanked, and all anodes are released
//   on the first cycle of every slot so the previous digit's segments never
//   ghost onto the next anode.
//
// Ports
//   clk         system clock
//   reset       asynchronous active-low reset
//   bcd_code    packed BCD: [3:0] units .. [15:12] thousands
//   bcd_valid   level qualifier; bcd_code is captured on every edge it is high
//   seg         {g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW
//   an          one-hot anode select (an[0] = units), polarity set by AN_ACTIVE_LOW
//   frame_tick  one-cycle pulse in the first cycle of each frame
//   shown_code  BCD word currently on the display
module bcd_display_driver #(
    parameter int unsigned DIGIT_PERIOD   = 6750,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1,
    parameter bit          BLANK_LEADING  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bcd_code,
    input  logic        bcd_valid,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_tick,
    output logic [15:0] shown_code
);

    localparam int unsigned      CNT_W    = (DIGIT_PERIOD > 2) ? $clog2(DIGIT_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_PERIOD - 1);
    localparam logic [6:0]       SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0]       AN_OFF   = AN_ACTIVE_LOW ? 4'hF : 4'h0;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      pending_q, pending_d;
    logic             pend_flag_q, pend_flag_d;
    logic [15:0]      shown_q, shown_d;
    logic             disp_en_q, disp_en_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;
    logic             frame_tick_q, frame_tick_d;

    logic             wrap;
    logic             boundary;
    logic [3:0]       nib;
    logic             upper_zero;
    logic             blank;
    logic [6:0]       seg_on;
    logic [3:0]       an_on;

    // Active-high segment pattern; codes 10-15 show a dash so a corrupted
    // BCD digit is visible rather than silently rendered as something else.
    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    always_comb begin
        wrap        = (cnt_q == CNT_LAST);
        boundary    = wrap && (idx_q == 2'd3);

        cnt_d       = wrap ? '0 : cnt_q + 1'b1;
        idx_d       = wrap ? idx_q + 2'd1 : idx_q;

        pending_d   = pending_q;
        pend_flag_d = pend_flag_q;
        shown_d     = shown_q;
        disp_en_d   = disp_en_q;

        if (boundary && pend_flag_q) begin
            shown_d     = pending_q;
            disp_en_d   = 1'b1;
            pend_flag_d = 1'b0;
        end
        // Capture after the transfer so a word arriving on the boundary edge
        // stays pending for the next frame instead of being lost.
        if (bcd_valid) begin
            pending_d   = bcd_code;
            pend_flag_d = 1'b1;
        end

        // Outputs are computed from next-state values so the registered
        // seg/an line up with the cnt/idx/shown of the same cycle.
        case (idx_d)
            2'd0: begin
                nib        = shown_d[3:0];
                upper_zero = 1'b0;
            end
            2'd1: begin
                nib        = shown_d[7:4];
                upper_zero = (shown_d[15:4] == 12'h000);
            end
            2'd2: begin
                nib        = shown_d[11:8];
                upper_zero = (shown_d[15:8] == 8'h00);
            end
            default: begin
                nib        = shown_d[15:12];
                upper_zero = (shown_d[15:12] == 4'h0);
            end
        endcase

        blank        = BLANK_LEADING && upper_zero;
        seg_on       = (disp_en_d && !blank) ? seg_decode(nib) : 7'h00;
        // Anodes are released on cnt=0 of every slot to avoid ghosting.
        an_on        = (disp_en_d && (cnt_d != '0)) ? (4'b0001 << idx_d) : 4'b0000;

        seg_d        = seg_on ^ SEG_OFF;
        an_d         = an_on ^ AN_OFF;
        frame_tick_d = boundary;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            pending_q    <= 16'h0000;
            pend_flag_q  <= 1'b0;
            shown_q      <= 16'h0000;
            disp_en_q    <= 1'b0;
            seg_q        <= SEG_OFF;
            an_q         <= AN_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            pend_flag_q  <= pend_flag_d;
            shown_q      <= shown_d;
            disp_en_q    <= disp_en_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;
    assign shown_code = shown_q;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Bench for bcd_display_driver with DIGIT_PERIOD=4 and default polarities.
// A cycle model predicts outputs into a scoreboard queue as stimulus is
// driven; each scenario task pops and compares, and adds literal checks for
// the digit patterns of interest.
module tb_bcd_display_driver;

    localparam int DP = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] bcd_code = 16'h0000;
    logic        bcd_valid = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;
    logic [15:0] shown_code;

    always #5 clk = ~clk;

    bcd_display_driver #(
        .DIGIT_PERIOD  (DP),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW (1'b1),
        .BLANK_LEADING (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bcd_code  (bcd_code),
        .bcd_valid (bcd_valid),
        .seg       (seg),
        .an        (an),
        .frame_tick(frame_tick),
        .shown_code(shown_code)
    );

    typedef struct {
        logic [6:0]  seg;
        logic [3:0]  an;
        logic        ft;
        logic [15:0] code;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int          cnt_m, idx_m;
    logic [15:0] pend_m, shown_m;
    logic        pflag_m, en_m;

    localparam logic [3:0] AN_SEL [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    function automatic logic [6:0] seg_hi(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0: s = 7'h3F; 4'd1: s = 7'h06; 4'd2: s = 7'h5B; 4'd3: s = 7'h4F;
            4'd4: s = 7'h66; 4'd5: s = 7'h6D; 4'd6: s = 7'h7D; 4'd7: s = 7'h07;
            4'd8: s = 7'h7F; 4'd9: s = 7'h6F; default: s = 7'h40;
        endcase
        return s;
    endfunction

    task automatic model_reset();
        cnt_m = 0; idx_m = 0; pend_m = 16'h0; shown_m = 16'h0; pflag_m = 1'b0; en_m = 1'b0;
    endtask

    // Drive one clock of stimulus, advance the model across the edge and
    // push the outputs expected for the following cycle.
    task automatic drive_cycle(input logic v, input logic [15:0] code);
        exp_t e;
        logic bnd, blank;
        logic [3:0] nib;
        bcd_valid = v;
        bcd_code  = code;
        @(posedge clk);
        bnd = (cnt_m == DP - 1) && (idx_m == 3);
        if (cnt_m == DP - 1) begin
            cnt_m = 0;
            idx_m = (idx_m + 1) % 4;
        end else begin
            cnt_m = cnt_m + 1;
        end
        if (bnd && pflag_m) begin
            shown_m = pend_m; en_m = 1'b1; pflag_m = 1'b0;
        end
        if (v) begin
            pend_m = code; pflag_m = 1'b1;
        end
        e.ft   = bnd;
        e.code = shown_m;
        if (!en_m) begin
            e.seg = 7'h7F;
            e.an  = 4'hF;
        end else begin
            nib   = shown_m[4*idx_m +: 4];
            blank = (idx_m > 0) && ((shown_m >> (4*idx_m)) == 16'h0);
            e.seg = blank ? 7'h7F : ~seg_hi(nib);
            e.an  = (cnt_m == 0) ? 4'hF : AN_SEL[idx_m];
        end
        sb.push_back(e);
        @(negedge clk);
        bcd_valid = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        int ticks;
        int tick_at[$];
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({seg, an, frame_tick, shown_code} !== {7'h7F, 4'hF, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset_state seg=%h an=%h ft=%b code=%h expected 7f f 0 0000", seg, an, frame_tick, shown_code);
        end
        reset = 1'b1;
        model_reset();
        ticks = 0;
        for (int c = 1; c <= 3 * 4 * DP; c++) begin
            drive_cycle(1'b0, 16'h0000);
            e = sb.pop_front();
            n_checks++;
            if ({seg, an, frame_tick, shown_code} !== {e.seg, e.an, e.ft, e.code}) begin
                n_fail++;
                $display("FAIL idle_frames cyc=%0d seg=%h an=%h ft=%b code=%h expected %h %h %b %h",
                         c, seg, an, frame_tick, shown_code, e.seg, e.an, e.ft, e.code);
            end
            if (frame_tick === 1'b1) begin
                ticks++;
                tick_at.push_back(c);
            end
        end
        n_checks++;
        if (ticks != 3 || tick_at[0] != 4 * DP) begin
            n_fail++;
            $display("FAIL idle_tick_count got %0d ticks (first at %0d) expected 3 (first at %0d)",
                     ticks, (ticks > 0) ? tick_at[0] : -1, 4 * DP);
        end
    endtask

    task automatic test_digits_1234();
        exp_t e;
        localparam logic [6:0] SEGS [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
        drive_cycle(1'b1, 16'h1234);
        void'(sb.pop_front());
        for (int c = 0; c < 2 * 4 * DP; c++) begin
            drive_cycle(1'b0, 16'h0000);
            e = sb.pop_front();
            n_checks++;
            if ({seg, an, frame_tick, shown_code} !== {e.seg, e.an, e.ft, e.code}) begin
                n_fail++;
                $display("FAIL digits_1234 cyc=%0d seg=%h an=%h ft=%b code=%h expected %h %h %b %h",
                         c, seg, an, frame_tick, shown_code, e.seg, e.an, e.ft, e.code);
            end
            if (en_m) begin
                n_checks++;
                if (cnt_m == 0 && an !== 4'hF) begin
                    n_fail++;
                    $display("FAIL ghost_guard cyc=%0d an=%h expected f", c, an);
                end else if (cnt_m != 0 && {an, seg} !== {AN_SEL[idx_m], SEGS[idx_m]}) begin
                    n_fail++;
                    $display("FAIL digit_pattern_1234 idx=%0d an=%h seg=%h expected %h %h",
                             idx_m, an, seg, AN_SEL[idx_m], SEGS[idx_m]);
                end
            end
        end
        n_checks++;
        if (shown_code !== 16'h1234) begin
            n_fail++;
            $display("FAIL shown_1234 code=%h expected 1234", shown_code);
        end
    endtask

    // Shows one word for two frames and checks every selected digit against
    // the literal segment table given in segs.
    task automatic test_pattern(input string name, input logic [15:0] word,
                                input logic [6:0] s0, input logic [6:0] s1,
                                input logic [6:0] s2, input logic [6:0] s3);
        exp_t e;
        logic [6:0] segs [4];
        segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
        drive_cycle(1'b1, word);
        void'(sb.pop_front());
        for (int c = 0; c < 2 * 4 * DP; c++) begin
            drive_cycle(1'b0, 16'h0000);
            e = sb.pop_front();
            n_checks++;
            if ({seg, an, frame_tick, shown_code} !== {e.seg, e.an, e.ft, e.code}) begin
                n_fail++;
                $display("FAIL %s cyc=%0d seg=%h an=%h ft=%b code=%h expected %h %h %b %h",
                         name, c, seg, an, frame_tick, shown_code, e.seg, e.an, e.ft, e.code);
            end
            if (en_m && shown_m == word && cnt_m != 0) begin
                n_checks++;
                if ({an, seg} !== {AN_SEL[idx_m], segs[idx_m]}) begin
                    n_fail++;
                    $display("FAIL %s_literal idx=%0d an=%h seg=%h expected %h %h",
                             name, idx_m, an, seg, AN_SEL[idx_m], segs[idx_m]);
                end
            end
        end
        n_checks++;
        if (shown_code !== word) begin
            n_fail++;
            $display("FAIL %s_shown code=%h expected %h", name, shown_code, word);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int guard;
        guard = 0;
        while (!(idx_m == 1 && cnt_m == 1) && guard < 4 * DP) begin
            drive_cycle(1'b0, 16'h0000); void'(sb.pop_front()); guard++;
        end
        drive_cycle(1'b1, 16'h0999); void'(sb.pop_front());
        guard = 0;
        while (!(idx_m == 3 && cnt_m == DP - 1) && guard < 4 * DP) begin
            drive_cycle(1'b0, 16'h0000); void'(sb.pop_front()); guard++;
        end
        drive_cycle(1'b1, 16'h0321);
        e = sb.pop_front();
        n_checks++;
        if ({shown_code, frame_tick} !== {16'h0999, 1'b1} || e.code !== 16'h0999) begin
            n_fail++;
            $display("FAIL b2b_first code=%h ft=%b expected 0999 1", shown_code, frame_tick);
        end
        for (int c = 1; c <= 4 * DP; c++) begin
            drive_cycle(1'b0, 16'h0000);
            e = sb.pop_front();
            n_checks++;
            if ({seg, an, frame_tick, shown_code} !== {e.seg, e.an, e.ft, e.code}
                || shown_code !== ((c < 4 * DP) ? 16'h0999 : 16'h0321)) begin
                n_fail++;
                $display("FAIL b2b_hold cyc=%0d seg=%h an=%h ft=%b code=%h expected %h %h %b %h",
                         c, seg, an, frame_tick, shown_code, e.seg, e.an, e.ft,
                         (c < 4 * DP) ? 16'h0999 : 16'h0321);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        exp_t e;
        drive_cycle(1'b1, 16'h1234); void'(sb.pop_front());
        for (int c = 0; c < 2 * 4 * DP + 5; c++) begin
            drive_cycle(1'b0, 16'h0000); void'(sb.pop_front());
        end
        n_checks++;
        if (shown_code !== 16'h1234) begin
            n_fail++;
            $display("FAIL pre_reset_code code=%h expected 1234", shown_code);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({seg, an, frame_tick, shown_code} !== {7'h7F, 4'hF, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL async_reset seg=%h an=%h ft=%b code=%h expected 7f f 0 0000", seg, an, frame_tick, shown_code);
        end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        for (int c = 1; c <= 3 * 4 * DP; c++) begin
            drive_cycle(1'b0, 16'h0000);
            e = sb.pop_front();
            n_checks++;
            if ({seg, an, frame_tick, shown_code} !== {e.seg, e.an, e.ft, e.code}
                || {seg, an, shown_code} !== {7'h7F, 4'hF, 16'h0000}) begin
                n_fail++;
                $display("FAIL post_reset_blank cyc=%0d seg=%h an=%h ft=%b code=%h expected 7f f %b 0000",
                         c, seg, an, frame_tick, shown_code, e.ft);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_digits_1234();
        test_pattern("blank_0070", 16'h0070, 7'h40, 7'h78, 7'h7F, 7'h7F);
        test_pattern("blank_0000", 16'h0000, 7'h40, 7'h7F, 7'h7F, 7'h7F);
        test_pattern("dash_00A5",  16'h00A5, 7'h12, 7'h3F, 7'h7F, 7'h7F);
        test_back_to_back();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
